cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Synthesizable run controller that sits beside CPU_Top in the simulation and FPGA harness.
//  - Drives the CPU reset sequence and counts run cycles.
//  - Stops the run on done, on a PC breakpoint or on a cycle timeout.
//  - Records register-writeback events {PC, F} in a circular trace buffer that the bench or host reads out.
//  - Replaces the fixed reset pulse and fixed-length #delay run of the old harness with a parametrised, observable one.
// PARAMETERS
//  PC_W        8     width of CPU program counter
//  DATA_W      32    width of ALU result F
//  TRACE_DEPTH 16    trace entries; power of two, >=2
//  RST_CYCLES  2     cycles cpu_reset held high in RST state; >=1
//  TIMEOUT     1500  RUN cycles before forced halt; 0 = disabled
// PORTS
//  CP          in   1              clock, rising edge
//  reset       in   1              synchronous, active-low controller reset
//  start       in   1              1-cycle pulse: begin (or restart) a run
//  bp_en       in   1              breakpoint enable
//  bp_pc       in   PC_W           breakpoint address
//  cpu_PC      in   PC_W           CPU program counter
//  cpu_writeReg in  1              CPU register write strobe
//  cpu_F       in   DATA_W         CPU ALU result / writeback data
//  cpu_done    in   1              CPU done flag
//  cpu_reset   out  1              active-high reset to CPU_Top
//  state       out  2              IDLE=0, RST=1, RUN=2, HALT=3
//  halt_cause  out  2              NONE=0, DONE=1, BREAK=2, TIMEOUT=3
//  cycles      out  32             RUN cycles elapsed; saturates at 32'hFFFF_FFFF
//  tr_rd       in   1              pop one trace entry
//  tr_data     out  PC_W+DATA_W    head entry {PC, F}, show-ahead; 0 when empty
//  tr_count    out  $clog2(TRACE_DEPTH)+1  entries held
//  tr_empty    out  1              tr_count==0
//  tr_overflow out  1              sticky: an entry was overwritten
// BEHAVIOUR
//  Reset (reset==0 at edge), also when asserted mid-run:
//    state=IDLE, cpu_reset=1, halt_cause=0, cycles=0, trace cleared, tr_overflow=0.
//  IDLE:
//    cpu_reset=1. start -> RST; clears cycles, halt_cause, trace and overflow.
//  RST:
//    cpu_reset=1 for exactly RST_CYCLES cycles (internal counter), then -> RUN.
//  RUN:
//    cpu_reset=0. cycles+=1 each cycle; start ignored.
//    Halt checks use values sampled at the edge, in priority order; state=HALT on the next cycle:
//      cpu_done                          -> cause DONE
//      bp_en && cpu_PC==bp_pc            -> cause BREAK
//      TIMEOUT!=0 && cycles+1==TIMEOUT   -> cause TIMEOUT
//  HALT:
//    cpu_reset=0 (CPU state left visible); cycles, cause and trace capture frozen; trace remains readable.
//    start -> RST with the same clears as from IDLE.
//  Trace push: state==RUN && cpu_writeReg; the halting cycle's writeback is also captured.
//  Full + push without pop: oldest entry dropped, new entry written, tr_overflow=1, count stays DEPTH.
//  Push and pop in the same cycle:
//    - non-empty: head advances and tail writes; count unchanged; no overflow.
//    - empty: push only.
//  Pop when empty: ignored.
//  Pointers wrap modulo TRACE_DEPTH.
//  Latency: push visible on tr_data/tr_count 1 cycle after the edge.
//  Simultaneous start and reset==0: reset wins.
// STRUCTURE
//  Package cpu_run_pkg:
//    - state encodings ST_IDLE/ST_RST/ST_RUN/ST_HALT.
//    - cause codes HC_NONE/HC_DONE/HC_BREAK/HC_TIMEOUT.
//  Sub-module trace_fifo #(W,DEPTH):
//    - circular buffer with overwrite-on-full and sticky overflow.
//    - receives the same CP and active-low synchronous reset, plus a clear input.
//  Top holds the FSM, RST counter, cycle counter and halt logic.
// TESTING
//  1 reset=0 for 2 cycles, then 1 -> state=0, cpu_reset=1, tr_empty=1, cycles=0.
//  2 start; cpu_done rises on 20th RUN cycle
//      -> cpu_reset high for exactly 2 cycles; state=HALT, cause=1, cycles=20.
//  3 bp_en=1, bp_pc=8'h0C, stub PC steps by 4 from 0
//      -> halt cause=2 one cycle after PC==0C; done at that edge instead gives cause=1.
//  4 TIMEOUT=50, done never rises -> HALT after 50 RUN cycles, cause=3, cycles=50.
//  5 DEPTH=4; 6 writebacks F=1..6, no reads
//      -> tr_count=4, overflow=1, pops return F=3,4,5,6, then tr_empty=1.
//  6 reset=0 mid-RUN -> next cycle IDLE, cpu_reset=1, trace and overflow cleared.
//    Restart from HALT -> cycles reset to 0.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run controller: FSM states, halt causes and counter limits.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_DONE    = 2'd1,
        HC_BREAK   = 2'd2,
        HC_TIMEOUT = 2'd3
    } cause_e;

    localparam logic [31:0] CYCLES_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// CPU-side and trace read-out signals of the run controller, grouped as one bundle.
interface cpu_run_ctrl_if #(
    parameter int PC_W        = 8,
    parameter int DATA_W      = 32,
    parameter int TRACE_DEPTH = 16
);
    // No backpressure anywhere: cpu_writeReg is a push strobe that is always accepted,
    // and tr_rd pops the head entry on the edge it is sampled high while tr_empty==0.
    logic                          cpu_reset;
    logic [PC_W-1:0]               cpu_PC;
    logic                          cpu_writeReg;
    logic [DATA_W-1:0]             cpu_F;
    logic                          cpu_done;
    logic                          tr_rd;
    logic [PC_W+DATA_W-1:0]        tr_data;
    logic [$clog2(TRACE_DEPTH):0]  tr_count;
    logic                          tr_empty;
    logic                          tr_overflow;

    modport master (
        output cpu_reset, tr_data, tr_count, tr_empty, tr_overflow,
        input  cpu_PC, cpu_writeReg, cpu_F, cpu_done, tr_rd
    );

    modport slave (
        input  cpu_reset, tr_data, tr_count, tr_empty, tr_overflow,
        output cpu_PC, cpu_writeReg, cpu_F, cpu_done, tr_rd
    );

endinterface

// File: rtl/cpu_run_ctrl_trace_fifo.sv
// Circular trace buffer: overwrites the oldest entry when full and latches a sticky overflow flag.
module trace_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 16
) (
    input  logic                     CP,
    input  logic                     reset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_overflow;

    wire w_full   = (r_count == (AW+1)'(DEPTH));
    wire w_do_pop = i_pop && (r_count != '0);

    always_ff @(posedge CP) begin
        if (i_push) begin
            r_mem[r_tail] <= i_din;
        end
    end

    always_ff @(posedge CP) begin
        if (!reset || i_clear) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + AW'(1);
            end
            // A push into a full buffer evicts the head even when nobody popped it.
            if (w_do_pop || (i_push && w_full)) begin
                r_head <= r_head + AW'(1);
            end
            if (i_push && !w_do_pop && !w_full) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!i_push && w_do_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if (i_push && w_full && !w_do_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_dout     = (r_count == '0) ? '0 : r_mem[r_head];
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);
    assign o_overflow = r_overflow;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller beside CPU_Top: sequences CPU reset, counts run cycles, halts on done/breakpoint/timeout.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int DATA_W      = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int RST_CYCLES  = 2,
    parameter int TIMEOUT     = 1500
) (
    input  logic                 CP,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 bp_en,
    input  logic [PC_W-1:0]      bp_pc,
    cpu_run_ctrl_if.master       bus,
    output logic [1:0]           state,
    output logic [1:0]           halt_cause,
    output logic [31:0]          cycles
);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e          r_state;
    cause_e          r_cause;
    logic [31:0]     r_cycles;
    logic [RC_W-1:0] r_rst_cnt;
    logic            r_cpu_reset;

    wire w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
    wire w_push     = (r_state == ST_RUN) && bus.cpu_writeReg;
    wire w_hit_bp   = bp_en && (bus.cpu_PC == bp_pc);
    wire w_hit_to   = (TIMEOUT != 0) && (({1'b0, r_cycles} + 33'd1) == 33'(TIMEOUT));

    always_ff @(posedge CP) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cause     <= HC_NONE;
            r_cycles    <= '0;
            r_rst_cnt   <= '0;
            r_cpu_reset <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_state     <= ST_RST;
                        r_cause     <= HC_NONE;
                        r_cycles    <= '0;
                        r_rst_cnt   <= '0;
                        r_cpu_reset <= 1'b1;
                    end
                end
                ST_RST: begin
                    if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        r_state     <= ST_RUN;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RC_W'(1);
                    end
                end
                ST_RUN: begin
                    if (r_cycles != CYCLES_MAX) begin
                        r_cycles <= r_cycles + 32'd1;
                    end
                    // Priority: done beats breakpoint beats timeout when they coincide.
                    if (bus.cpu_done) begin
                        r_state <= ST_HALT;
                        r_cause <= HC_DONE;
                    end else if (w_hit_bp) begin
                        r_state <= ST_HALT;
                        r_cause <= HC_BREAK;
                    end else if (w_hit_to) begin
                        r_state <= ST_HALT;
                        r_cause <= HC_TIMEOUT;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cpu_reset <= 1'b1;
                end
            endcase
        end
    end

    trace_fifo #(
        .W     (PC_W + DATA_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .CP         (CP),
        .reset      (reset),
        .i_clear    (w_start_ok),
        .i_push     (w_push),
        .i_din      ({bus.cpu_PC, bus.cpu_F}),
        .i_pop      (bus.tr_rd),
        .o_dout     (bus.tr_data),
        .o_count    (bus.tr_count),
        .o_empty    (bus.tr_empty),
        .o_overflow (bus.tr_overflow)
    );

    assign bus.cpu_reset = r_cpu_reset;
    assign state         = r_state;
    assign halt_cause    = r_cause;
    assign cycles        = r_cycles;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: table of run scenarios plus reset/restart sequences, trace checked by a scoreboard.
module tb_cpu_run_ctrl;
    import cpu_run_pkg::*;

    localparam int PC_W   = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int RSTC   = 2;
    localparam int TO     = 50;
    localparam int W      = PC_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic            CP = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            bp_en = 1'b0;
    logic [PC_W-1:0] bp_pc = '0;
    logic [1:0]      state;
    logic [1:0]      halt_cause;
    logic [31:0]     cycles;

    always #5 CP = ~CP;

    cpu_run_ctrl_if #(.PC_W(PC_W), .DATA_W(DATA_W), .TRACE_DEPTH(DEPTH)) bus ();

    cpu_run_ctrl #(
        .PC_W(PC_W), .DATA_W(DATA_W), .TRACE_DEPTH(DEPTH),
        .RST_CYCLES(RSTC), .TIMEOUT(TO)
    ) dut (
        .CP         (CP),
        .reset      (reset),
        .start      (start),
        .bp_en      (bp_en),
        .bp_pc      (bp_pc),
        .bus        (bus),
        .state      (state),
        .halt_cause (halt_cause),
        .cycles     (cycles)
    );

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [W-1:0] exp_q[$];
    bit          exp_ovf;

    typedef struct {
        bit              bp_en;
        logic [PC_W-1:0] bp_pc;
        int              done_k;     // RUN cycle whose edge sees cpu_done=1; 0 = never
        bit              seq_f;      // writebacks F=1..6 on cycles 1..6, no reads
        bit              drain_all;
        logic [1:0]      exp_cause;
        int              exp_cycles;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit wr, input logic [DATA_W-1:0] f, input logic [PC_W-1:0] pc,
                        input bit done, input bit rd, input bit run);
        bit popped;
        bus.cpu_writeReg = wr;
        bus.cpu_F        = f;
        bus.cpu_PC       = pc;
        bus.cpu_done     = done;
        bus.tr_rd        = rd;
        popped = rd && (exp_q.size() != 0);
        if (popped) check("tr_data_head", bus.tr_data, exp_q[0]);
        tick();
        if (popped) void'(exp_q.pop_front());
        if (run && wr) begin
            if (exp_q.size() == DEPTH) begin
                void'(exp_q.pop_front());
                exp_ovf = 1'b1;
            end
            exp_q.push_back({pc, f});
        end
        check("tr_count", bus.tr_count, exp_q.size());
        bus.cpu_writeReg = 1'b0;
        bus.cpu_done     = 1'b0;
        bus.tr_rd        = 1'b0;
    endtask

    task automatic start_run(input bit bpe, input logic [PC_W-1:0] bpp);
        bp_en = bpe;
        bp_pc = bpp;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        check("start_state", state, 64'(ST_RST));
        check("start_cycles", cycles, 0);
        check("start_cause", halt_cause, 64'(HC_NONE));
        check("start_empty", bus.tr_empty, 1);
        check("start_ovf", bus.tr_overflow, 0);
        check("rst_cpu_reset1", bus.cpu_reset, 1);
        tick();
        check("rst_cpu_reset2", bus.cpu_reset, 1);
        check("rst_state2", state, 64'(ST_RST));
        tick();
        check("run_cpu_reset", bus.cpu_reset, 0);
        check("run_state", state, 64'(ST_RUN));
    endtask

    task automatic run_case(input vec_t v);
        logic [31:0] held_cycles;
        int n;
        start_run(v.bp_en, v.bp_pc);
        for (int k = 1; k <= v.exp_cycles; k++) begin
            if (v.seq_f)
                step(k <= 6, DATA_W'(k), PC_W'(4 * (k - 1)), k == v.done_k, 1'b0, 1'b1);
            else
                step(1'($urandom_range(0, 1)), $urandom, PC_W'(4 * (k - 1)), k == v.done_k,
                     $urandom_range(0, 3) == 0, 1'b1);
        end
        check("halt_state", state, 64'(ST_HALT));
        check("halt_cause", halt_cause, v.exp_cause);
        check("halt_cycles", cycles, v.exp_cycles);
        check("halt_cpu_reset", bus.cpu_reset, 0);
        check("halt_ovf", bus.tr_overflow, exp_ovf);
        held_cycles = cycles;
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 8'hAA, 1'b1, 1'b0, 1'b0);
        check("frozen_cycles", cycles, held_cycles);
        check("frozen_cause", halt_cause, v.exp_cause);
        check("frozen_state", state, 64'(ST_HALT));
        n = v.drain_all ? exp_q.size() : ((exp_q.size() < 2) ? exp_q.size() : 2);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        if (v.drain_all) begin
            check("drained_empty", bus.tr_empty, 1);
            check("drained_data", bus.tr_data, 0);
            step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            check("pop_empty_ignored", bus.tr_empty, 1);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.cpu_PC       = '0;
        bus.cpu_writeReg = 1'b0;
        bus.cpu_F        = '0;
        bus.cpu_done     = 1'b0;
        bus.tr_rd        = 1'b0;

        vecs[0] = '{1'b0, 8'h00, 20, 1'b1, 1'b1, 2'(HC_DONE),    20};
        vecs[1] = '{1'b1, 8'h0C,  0, 1'b0, 1'b0, 2'(HC_BREAK),    4};
        vecs[2] = '{1'b1, 8'h0C,  4, 1'b0, 1'b0, 2'(HC_DONE),     4};
        vecs[3] = '{1'b0, 8'h00,  0, 1'b0, 1'b1, 2'(HC_TIMEOUT), 50};
        vecs[4] = '{1'b1, 8'h10,  0, 1'b0, 1'b0, 2'(HC_BREAK),    5};
        vecs[5] = '{1'b1, 8'h00,  0, 1'b0, 1'b0, 2'(HC_BREAK),    1};
        vecs[6] = '{1'b1, 8'hC4,  0, 1'b0, 1'b0, 2'(HC_BREAK),   50};
        vecs[7] = '{1'b1, 8'hFC,  0, 1'b0, 1'b1, 2'(HC_TIMEOUT), 50};
        vecs[8] = '{1'b1, 8'h40,  9, 1'b0, 1'b0, 2'(HC_DONE),     9};

        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("rst_state", state, 64'(ST_IDLE));
        check("rst_cpu_reset", bus.cpu_reset, 1);
        check("rst_empty", bus.tr_empty, 1);
        check("rst_cycles", cycles, 0);
        check("rst_cause", halt_cause, 0);
        check("rst_ovf", bus.tr_overflow, 0);
        tick();
        check("idle_hold", state, 64'(ST_IDLE));

        for (int i = 0; i < 9; i++) run_case(vecs[i]);

        // Reset while running, asserted together with start: reset must win.
        start_run(1'b0, '0);
        for (int k = 1; k <= 8; k++) step(1'b1, DATA_W'(100 + k), PC_W'(4 * (k - 1)), 1'b0, 1'b0, 1'b1);
        check("midrun_ovf_set", bus.tr_overflow, 1);
        reset = 1'b0;
        start = 1'b1;
        tick();
        reset = 1'b1;
        start = 1'b0;
        exp_q.delete();
        check("midrst_state", state, 64'(ST_IDLE));
        check("midrst_cpu_reset", bus.cpu_reset, 1);
        check("midrst_empty", bus.tr_empty, 1);
        check("midrst_count", bus.tr_count, 0);
        check("midrst_ovf", bus.tr_overflow, 0);
        check("midrst_cycles", cycles, 0);
        check("midrst_cause", halt_cause, 0);
        tick();
        check("midrst_idle", state, 64'(ST_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
